// File: rtl/led_pattern_shifter.sv
// LED pattern shifter: rotate-left / rotate-right / hold with a prescaled step tick.
// Define LED_PATTERN_PINGPONG_EN to compile in the ping-pong (bounce) mode on i_mode=10.
module led_pattern_shifter #(
    parameter int NB_LEDS  = 4,
    parameter int NB_COUNT = 24
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [1:0]          i_mode,
    input  logic [NB_COUNT-1:0] i_prescale,
    input  logic                i_load,
    input  logic [NB_LEDS-1:0]  i_pattern,
    output logic [NB_LEDS-1:0]  o_led,
    output logic                o_wrap,
    output logic                o_dir
);

    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [NB_LEDS-1:0]  LED_INIT = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_COUNT-1:0] CNT_ONE  = {{(NB_COUNT-1){1'b0}}, 1'b1};

    logic [NB_LEDS-1:0]  r_led;
    logic [NB_LEDS-1:0]  w_led_next;
    logic [NB_COUNT-1:0] r_cnt;
    logic                r_wrap;
    logic                w_wrap_next;
    logic                w_run;
    logic                w_tick;

`ifdef LED_PATTERN_PINGPONG_EN
    localparam logic [1:0] MODE_PP = 2'b10;

    logic r_dir;
    logic w_dir_next;

    assign w_run = i_valid && (i_mode != MODE_HOLD);
`else
    // Without ping-pong, mode 10 behaves like hold: the prescaler is frozen too.
    assign w_run = i_valid && (i_mode != MODE_HOLD) && !i_mode[1];
`endif

    assign w_tick = w_run && !i_load && (r_cnt >= i_prescale);

    always_comb begin
        w_led_next  = r_led;
        w_wrap_next = 1'b0;
`ifdef LED_PATTERN_PINGPONG_EN
        w_dir_next  = r_dir;
`endif
        if (w_tick) begin
            case (i_mode)
                MODE_ROL: begin
                    w_led_next  = {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};
                    w_wrap_next = r_led[NB_LEDS-1];
                end
                MODE_ROR: begin
                    w_led_next  = {r_led[0], r_led[NB_LEDS-1:1]};
                    w_wrap_next = r_led[0];
                end
`ifdef LED_PATTERN_PINGPONG_EN
                MODE_PP: begin
                    // Both ends lit: nowhere to go, so only the direction flips.
                    if (r_led[NB_LEDS-1] && r_led[0]) begin
                        w_dir_next  = !r_dir;
                        w_wrap_next = 1'b1;
                    end else if (!r_dir) begin
                        if (!r_led[NB_LEDS-1]) begin
                            w_led_next = r_led << 1;
                        end else begin
                            w_led_next  = r_led >> 1;
                            w_dir_next  = 1'b1;
                            w_wrap_next = 1'b1;
                        end
                    end else begin
                        if (!r_led[0]) begin
                            w_led_next = r_led >> 1;
                        end else begin
                            w_led_next  = r_led << 1;
                            w_dir_next  = 1'b0;
                            w_wrap_next = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    w_led_next  = r_led;
                    w_wrap_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= (r_cnt >= i_prescale) ? '0 : (r_cnt + CNT_ONE);
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_led  <= LED_INIT;
            r_wrap <= 1'b0;
        end else if (i_load) begin
            r_led  <= i_pattern;
            r_wrap <= 1'b0;
        end else begin
            r_led  <= w_led_next;
            r_wrap <= w_wrap_next;
        end
    end

`ifdef LED_PATTERN_PINGPONG_EN
    always_ff @(posedge clock) begin
        if (!i_reset || i_load) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= w_dir_next;
        end
    end

    assign o_dir = r_dir;
`else
    assign o_dir = 1'b0;
`endif

    assign o_led  = r_led;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed bench for led_pattern_shifter (NB_LEDS=4); follows LED_PATTERN_PINGPONG_EN if defined.
module tb_led_pattern_shifter;

    logic        clock;
    logic        i_reset;
    logic        i_valid;
    logic [1:0]  i_mode;
    logic [23:0] i_prescale;
    logic        i_load;
    logic [3:0]  i_pattern;
    logic [3:0]  o_led;
    logic        o_wrap;
    logic        o_dir;

    int checks = 0;
    int errors = 0;

    led_pattern_shifter #(.NB_LEDS(4), .NB_COUNT(24)) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_mode     (i_mode),
        .i_prescale (i_prescale),
        .i_load     (i_load),
        .i_pattern  (i_pattern),
        .o_led      (o_led),
        .o_wrap     (o_wrap),
        .o_dir      (o_dir)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare outputs 1 time unit later.
    task automatic cyc(input string tag, input logic [3:0] e_led, input logic e_wrap, input logic e_dir);
        @(posedge clock);
        #1;
        chk({tag, ".led"}, {28'd0, o_led}, {28'd0, e_led});
        chk({tag, ".wrap"}, {31'd0, o_wrap}, {31'd0, e_wrap});
        chk({tag, ".dir"}, {31'd0, o_dir}, {31'd0, e_dir});
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        @(posedge clock);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_valid    = 1'b0;
        i_mode     = 2'b00;
        i_prescale = 24'd0;
        i_load     = 1'b0;
        i_pattern  = 4'b0000;

        cyc("reset", 4'b0001, 1'b0, 1'b0);

        // Rotate-left every cycle.
        i_reset = 1'b1; i_valid = 1'b1; i_mode = 2'b00; i_prescale = 24'd0;
        cyc("rol1", 4'b0010, 1'b0, 1'b0);
        cyc("rol2", 4'b0100, 1'b0, 1'b0);
        cyc("rol3", 4'b1000, 1'b0, 1'b0);
        cyc("rol4", 4'b0001, 1'b1, 1'b0);
        cyc("rol5", 4'b0010, 1'b0, 1'b0);

        // Rotate-right with prescale 2, then a 5-cycle valid gap.
        do_reset();
        i_prescale = 24'd2; i_mode = 2'b01; i_valid = 1'b1;
        cyc("ror_c1", 4'b0001, 1'b0, 1'b0);
        cyc("ror_c2", 4'b0001, 1'b0, 1'b0);
        cyc("ror_s1", 4'b1000, 1'b1, 1'b0);
        cyc("ror_c4", 4'b1000, 1'b0, 1'b0);
        cyc("ror_c5", 4'b1000, 1'b0, 1'b0);
        cyc("ror_s2", 4'b0100, 1'b0, 1'b0);
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) cyc("ror_gap", 4'b0100, 1'b0, 1'b0);
        i_valid = 1'b1;
        cyc("ror_c7", 4'b0100, 1'b0, 1'b0);
        cyc("ror_c8", 4'b0100, 1'b0, 1'b0);
        cyc("ror_s3", 4'b0010, 1'b0, 1'b0);

        // Reset together with load while cnt=1, prescale 3.
        do_reset();
        i_prescale = 24'd3; i_mode = 2'b00; i_valid = 1'b1;
        cyc("rl_pre", 4'b0001, 1'b0, 1'b0);
        i_reset = 1'b0; i_load = 1'b1; i_pattern = 4'b1111;
        cyc("rl_rst", 4'b0001, 1'b0, 1'b0);
        i_reset = 1'b1; i_load = 1'b0;
        cyc("rl_c1", 4'b0001, 1'b0, 1'b0);
        cyc("rl_c2", 4'b0001, 1'b0, 1'b0);
        cyc("rl_c3", 4'b0001, 1'b0, 1'b0);
        cyc("rl_s1", 4'b0010, 1'b0, 1'b0);

        // Mid-count prescale change: cnt=2 against new prescale 1 ticks at once.
        cyc("pc_c1", 4'b0010, 1'b0, 1'b0);
        cyc("pc_c2", 4'b0010, 1'b0, 1'b0);
        i_prescale = 24'd1;
        cyc("pc_s", 4'b0100, 1'b0, 1'b0);

        // Hold mode 11 freezes counter; load clears it.
        i_load = 1'b1; i_pattern = 4'b1000; i_mode = 2'b11;
        cyc("ld_hold", 4'b1000, 1'b0, 1'b0);
        i_load = 1'b0;
        for (int k = 0; k < 3; k++) cyc("hold", 4'b1000, 1'b0, 1'b0);
        i_mode = 2'b00;
        cyc("hold_c", 4'b1000, 1'b0, 1'b0);
        cyc("hold_s", 4'b0001, 1'b1, 1'b0);

        // All-zero pattern stays zero without wrap.
        i_prescale = 24'd0;
        i_load = 1'b1; i_pattern = 4'b0000;
        cyc("zero_ld", 4'b0000, 1'b0, 1'b0);
        i_load = 1'b0;
        cyc("zero_rol", 4'b0000, 1'b0, 1'b0);
        i_mode = 2'b01;
        cyc("zero_ror", 4'b0000, 1'b0, 1'b0);
        i_mode = 2'b10;
        cyc("zero_m10", 4'b0000, 1'b0, 1'b0);

`ifdef LED_PATTERN_PINGPONG_EN
        // Ping-pong bounce from 0001.
        do_reset();
        i_mode = 2'b10; i_prescale = 24'd0; i_valid = 1'b1;
        cyc("pp1", 4'b0010, 1'b0, 1'b0);
        cyc("pp2", 4'b0100, 1'b0, 1'b0);
        cyc("pp3", 4'b1000, 1'b0, 1'b0);
        cyc("pp4", 4'b0100, 1'b1, 1'b1);
        cyc("pp5", 4'b0010, 1'b0, 1'b1);
        cyc("pp6", 4'b0001, 1'b0, 1'b1);
        cyc("pp7", 4'b0010, 1'b1, 1'b0);

        // Load on a tick cycle, then both-ends-lit toggles dir only.
        i_load = 1'b1; i_pattern = 4'b1001;
        cyc("ppld", 4'b1001, 1'b0, 1'b0);
        i_load = 1'b0;
        cyc("ppboth1", 4'b1001, 1'b1, 1'b1);
        cyc("ppboth2", 4'b1001, 1'b1, 1'b0);
`else
        // Mode 10 acts as hold, counter frozen at cnt=1.
        do_reset();
        i_mode = 2'b00; i_prescale = 24'd2; i_valid = 1'b1;
        cyc("m10_pre", 4'b0001, 1'b0, 1'b0);
        i_mode = 2'b10;
        for (int k = 0; k < 10; k++) cyc("m10_hold", 4'b0001, 1'b0, 1'b0);
        i_mode = 2'b00;
        cyc("m10_c", 4'b0001, 1'b0, 1'b0);
        cyc("m10_s", 4'b0010, 1'b0, 1'b0);

        // Load in mode 10 still applies and then holds.
        i_mode = 2'b10; i_prescale = 24'd0;
        i_load = 1'b1; i_pattern = 4'b1001;
        cyc("m10_ld", 4'b1001, 1'b0, 1'b0);
        i_load = 1'b0;
        cyc("m10_ld1", 4'b1001, 1'b0, 1'b0);
        cyc("m10_ld2", 4'b1001, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
